// File: rtl/reg_file_sb_if.sv
// Register-file bus: two read ports, two write-back ports, issue request and scoreboard outputs.
// The master modport is the decode/writeback side; the slave modport is the register file.
interface reg_file_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] REG_address1;
  logic [ADDR_W-1:0] REG_address2;
  logic [DATA_W-1:0] REG_data_out1;
  logic [DATA_W-1:0] REG_data_out2;
  logic              REG_write_1;
  logic [ADDR_W-1:0] REG_address_wr1;
  logic [DATA_W-1:0] REG_data_wb_in1;
  logic              REG_write_2;
  logic [ADDR_W-1:0] REG_address_wr2;
  logic [DATA_W-1:0] REG_data_wb_in2;
  logic              REG_issue;
  logic [ADDR_W-1:0] REG_issue_address;
  logic              REG_busy1;
  logic              REG_busy2;
  logic              REG_stall;
  logic [ADDR_W:0]   REG_pending_cnt;

  modport master (
    output REG_address1, REG_address2,
    output REG_write_1, REG_address_wr1, REG_data_wb_in1,
    output REG_write_2, REG_address_wr2, REG_data_wb_in2,
    output REG_issue, REG_issue_address,
    input  REG_data_out1, REG_data_out2,
    input  REG_busy1, REG_busy2, REG_stall, REG_pending_cnt
  );

  modport slave (
    input  REG_address1, REG_address2,
    input  REG_write_1, REG_address_wr1, REG_data_wb_in1,
    input  REG_write_2, REG_address_wr2, REG_data_wb_in2,
    input  REG_issue, REG_issue_address,
    output REG_data_out1, REG_data_out2,
    output REG_busy1, REG_busy2, REG_stall, REG_pending_cnt
  );
endinterface

// File: rtl/reg_file_sb.sv
// 2-read/2-write register file with a per-register pending-write scoreboard driving RAW/WAW issue stalls.
// Reads combinational; writes visible next cycle, or same cycle with REG_BYPASS_EN defined; stall is combinational.
module reg_file_sb #(
  parameter int          DATA_W   = 32,
  parameter int          ADDR_W   = 5,
  parameter bit          ZERO_REG = 1'b1,
  parameter int unsigned RST_VAL  = 0
) (
  input logic          SYS_clk,
  input logic          SYS_reset_n,
  reg_file_sb_if.slave rf
);
  localparam int                DEPTH    = 1 << ADDR_W;
  localparam int                CNT_W    = ADDR_W + 1;
  localparam logic [DATA_W-1:0] RST_WORD = DATA_W'(RST_VAL);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  pending_q, pending_d;
  logic [CNT_W-1:0]  pending_cnt_q, pending_cnt_d;

  logic              we1, we2;
  logic [DATA_W-1:0] rd1, rd2;
  logic              busy1, busy2, waw, stall, accept;

  function automatic logic is_r0(input logic [ADDR_W-1:0] a);
    return ZERO_REG && (a == '0);
  endfunction

  // Writes to the hard-wired zero register never reach the array or the scoreboard.
  always_comb begin
    we1 = rf.REG_write_1 && !is_r0(rf.REG_address_wr1);
    we2 = rf.REG_write_2 && !is_r0(rf.REG_address_wr2);
  end

  always_comb begin
    rd1   = regs_q[rf.REG_address1];
    rd2   = regs_q[rf.REG_address2];
    busy1 = pending_q[rf.REG_address1];
    busy2 = pending_q[rf.REG_address2];
    waw   = pending_q[rf.REG_issue_address];
`ifdef REG_BYPASS_EN
    if (we1 && rf.REG_address_wr1 == rf.REG_address1) begin
      rd1   = rf.REG_data_wb_in1;
      busy1 = 1'b0;
    end
    if (we2 && rf.REG_address_wr2 == rf.REG_address1) begin
      rd1   = rf.REG_data_wb_in2;
      busy1 = 1'b0;
    end
    if (we1 && rf.REG_address_wr1 == rf.REG_address2) begin
      rd2   = rf.REG_data_wb_in1;
      busy2 = 1'b0;
    end
    if (we2 && rf.REG_address_wr2 == rf.REG_address2) begin
      rd2   = rf.REG_data_wb_in2;
      busy2 = 1'b0;
    end
    if ((we1 && rf.REG_address_wr1 == rf.REG_issue_address) ||
        (we2 && rf.REG_address_wr2 == rf.REG_issue_address)) begin
      waw = 1'b0;
    end
`endif
    if (is_r0(rf.REG_address1)) begin
      rd1   = '0;
      busy1 = 1'b0;
    end
    if (is_r0(rf.REG_address2)) begin
      rd2   = '0;
      busy2 = 1'b0;
    end
    stall  = rf.REG_issue && (busy1 || busy2 || waw);
    accept = rf.REG_issue && !stall;
  end

  always_comb begin
    regs_d = regs_q;
    if (we1) regs_d[rf.REG_address_wr1] = rf.REG_data_wb_in1;
    if (we2) regs_d[rf.REG_address_wr2] = rf.REG_data_wb_in2;

    pending_d = pending_q;
    if (we1) pending_d[rf.REG_address_wr1] = 1'b0;
    if (we2) pending_d[rf.REG_address_wr2] = 1'b0;
    // Set after clear: a newly issued producer supersedes the one writing back now.
    if (accept && !is_r0(rf.REG_issue_address)) pending_d[rf.REG_issue_address] = 1'b1;

    pending_cnt_d = pending_cnt_q
                  + CNT_W'($countones(pending_d & ~pending_q))
                  - CNT_W'($countones(pending_q & ~pending_d));
  end

  always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
    if (!SYS_reset_n) begin
      regs_q        <= '{default: RST_WORD};
      pending_q     <= '0;
      pending_cnt_q <= '0;
    end else begin
      regs_q        <= regs_d;
      pending_q     <= pending_d;
      pending_cnt_q <= pending_cnt_d;
    end
  end

  assign rf.REG_data_out1   = rd1;
  assign rf.REG_data_out2   = rd2;
  assign rf.REG_busy1       = busy1;
  assign rf.REG_busy2       = busy2;
  assign rf.REG_stall       = stall;
  assign rf.REG_pending_cnt = pending_cnt_q;
endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: directed scenarios then random traffic, all checked against a behavioural model.
module tb_reg_file_sb;
  localparam int          DATA_W = 32;
  localparam int          ADDR_W = 5;
  localparam int          DEPTH  = 1 << ADDR_W;
  localparam logic [31:0] RST_V  = 32'h1234_5678;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  reg_file_sb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) rf ();

  reg_file_sb #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(1'b1),
    .RST_VAL (RST_V)
  ) dut (
    .SYS_clk    (clk),
    .SYS_reset_n(rst_n),
    .rf         (rf)
  );

  always #5 clk = ~clk;

  // Architectural view: register contents and which registers await a writeback.
  logic [31:0] m_mem  [DEPTH];
  bit          m_pend [DEPTH];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]  = RST_V;
      m_pend[i] = 1'b0;
    end
  endtask

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) c += int'(m_pend[i]);
    return c;
  endfunction

  function automatic bit written_now(input int a);
    return (rf.REG_write_1 && int'(rf.REG_address_wr1) == a) ||
           (rf.REG_write_2 && int'(rf.REG_address_wr2) == a);
  endfunction

  function automatic logic [31:0] m_rd(input int a);
    if (a == 0) return 32'h0;
`ifdef REG_BYPASS_EN
    if (rf.REG_write_2 && int'(rf.REG_address_wr2) == a) return rf.REG_data_wb_in2;
    if (rf.REG_write_1 && int'(rf.REG_address_wr1) == a) return rf.REG_data_wb_in1;
`endif
    return m_mem[a];
  endfunction

  function automatic bit m_busy(input int a);
    if (a == 0) return 1'b0;
`ifdef REG_BYPASS_EN
    if (written_now(a)) return 1'b0;
`endif
    return m_pend[a];
  endfunction

  function automatic bit m_stall();
    return rf.REG_issue && (m_busy(int'(rf.REG_address1)) || m_busy(int'(rf.REG_address2)) ||
                            m_busy(int'(rf.REG_issue_address)));
  endfunction

  task automatic idle();
    rf.REG_address1      = '0;
    rf.REG_address2      = '0;
    rf.REG_write_1       = 1'b0;
    rf.REG_address_wr1   = '0;
    rf.REG_data_wb_in1   = '0;
    rf.REG_write_2       = 1'b0;
    rf.REG_address_wr2   = '0;
    rf.REG_data_wb_in2   = '0;
    rf.REG_issue         = 1'b0;
    rf.REG_issue_address = '0;
  endtask

  task automatic set_rd(input int a1, input int a2);
    rf.REG_address1 = ADDR_W'(a1);
    rf.REG_address2 = ADDR_W'(a2);
  endtask

  task automatic set_wr1(input int a, input logic [31:0] d);
    rf.REG_write_1     = 1'b1;
    rf.REG_address_wr1 = ADDR_W'(a);
    rf.REG_data_wb_in1 = d;
  endtask

  task automatic set_wr2(input int a, input logic [31:0] d);
    rf.REG_write_2     = 1'b1;
    rf.REG_address_wr2 = ADDR_W'(a);
    rf.REG_data_wb_in2 = d;
  endtask

  task automatic set_iss(input int a);
    rf.REG_issue         = 1'b1;
    rf.REG_issue_address = ADDR_W'(a);
  endtask

  task automatic settle();
    #1;
    check("rd1",   rf.REG_data_out1,   m_rd(int'(rf.REG_address1)));
    check("rd2",   rf.REG_data_out2,   m_rd(int'(rf.REG_address2)));
    check("busy1", rf.REG_busy1,       m_busy(int'(rf.REG_address1)));
    check("busy2", rf.REG_busy2,       m_busy(int'(rf.REG_address2)));
    check("stall", rf.REG_stall,       m_stall());
    check("cnt",   rf.REG_pending_cnt, m_count());
  endtask

  task automatic tick();
    bit acc;
    int ia;
    @(posedge clk);
    acc = rf.REG_issue && !m_stall();
    ia  = int'(rf.REG_issue_address);
    if (rf.REG_write_1 && rf.REG_address_wr1 != 0) m_mem[rf.REG_address_wr1] = rf.REG_data_wb_in1;
    if (rf.REG_write_2 && rf.REG_address_wr2 != 0) m_mem[rf.REG_address_wr2] = rf.REG_data_wb_in2;
    if (rf.REG_write_1) m_pend[rf.REG_address_wr1] = 1'b0;
    if (rf.REG_write_2) m_pend[rf.REG_address_wr2] = 1'b0;
    if (acc && ia != 0) m_pend[ia] = 1'b1;
    @(negedge clk);
  endtask

  task automatic cycle();
    settle();
    tick();
  endtask

  function automatic int rnd_addr();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DEPTH - 1)) : int'($urandom_range(0, 7));
  endfunction

  initial begin
    idle();
    m_reset();
    @(negedge clk);
    settle();
    @(negedge clk);
    rst_n = 1'b1;

    // Every register shows the reset value, r0 reads zero.
    for (int i = 0; i < DEPTH / 2; i++) begin
      idle(); set_rd(i, i + DEPTH / 2); cycle();
    end
    idle(); set_wr1(0, 32'hDEADBEEF); cycle();
    idle(); set_rd(0, 0); settle();
    check("t1_r0_zero", rf.REG_data_out1, 32'h0);
    tick();

    // RAW stall on r9 released by writeback.
    idle(); set_iss(9); cycle();
    idle(); set_rd(9, 0); set_iss(0); settle();
    check("t2_cnt", rf.REG_pending_cnt, 1);
    check("t2_busy1", rf.REG_busy1, 1);
    check("t2_stall", rf.REG_stall, 1);
    tick();
    idle(); set_rd(9, 0); set_iss(0); set_wr1(9, 32'd10); settle();
`ifdef REG_BYPASS_EN
    check("t2_byp_rd1", rf.REG_data_out1, 32'd10);
    check("t2_byp_stall", rf.REG_stall, 0);
`else
    check("t2_wb_stall", rf.REG_stall, 1);
`endif
    tick();
    idle(); set_rd(9, 0); set_iss(0); settle();
    check("t2_after_stall", rf.REG_stall, 0);
    check("t2_after_rd1", rf.REG_data_out1, 32'd10);
    tick();

    // Same-edge writes: port 2 wins.
    idle(); set_wr1(10, 32'd5); set_wr2(10, 32'd7); cycle();
    idle(); set_rd(10, 10); settle();
    check("t3_r10", rf.REG_data_out1, 32'd7);
    tick();

    // WAW on r11, then writeback and re-issue in the same cycle.
    idle(); set_iss(11); cycle();
    idle(); set_iss(11); settle();
    check("t4_waw_stall", rf.REG_stall, 1);
    tick();
    idle(); set_wr1(11, 32'd33); set_iss(11); settle();
    check("t4_cnt_hold", rf.REG_pending_cnt, 1);
`ifdef REG_BYPASS_EN
    check("t4_byp_stall", rf.REG_stall, 0);
`else
    check("t4_wb_stall", rf.REG_stall, 1);
`endif
    tick();
    idle(); settle();
`ifdef REG_BYPASS_EN
    check("t4_byp_cnt", rf.REG_pending_cnt, 1);
`else
    check("t4_cnt_dec", rf.REG_pending_cnt, 0);
`endif
    tick();
    idle(); set_wr1(11, 32'd44); cycle();

    // Two clears and one set in a single edge.
    for (int r = 1; r <= 5; r++) begin
      idle(); set_iss(r); cycle();
    end
    idle(); set_wr1(1, 32'h111); set_wr2(2, 32'h222); set_iss(6); settle();
    check("t5_cnt5", rf.REG_pending_cnt, 5);
    tick();

    // Asynchronous reset between edges wipes the scoreboard immediately.
    idle(); set_rd(3, 0); set_iss(3); settle();
    check("t5_cnt4", rf.REG_pending_cnt, 4);
    #1 rst_n = 1'b0;
    m_reset();
    #1;
    check("t6_cnt", rf.REG_pending_cnt, 0);
    check("t6_busy1", rf.REG_busy1, 0);
    check("t6_stall", rf.REG_stall, 0);
    settle();
    @(negedge clk);
    idle(); rst_n = 1'b1; set_rd(9, 9); settle();
    check("t6_r9", rf.REG_data_out1, RST_V);
    tick();

    // Fill the scoreboard: count tops out at DEPTH-1 with r0 excluded.
    for (int r = 1; r < DEPTH; r++) begin
      idle(); set_iss(r); cycle();
    end
    idle(); settle();
    check("fill_cnt", rf.REG_pending_cnt, DEPTH - 1);
    tick();

    for (int k = 0; k < 400; k++) begin
      idle();
      set_rd(rnd_addr(), rnd_addr());
      if ($urandom_range(0, 1) == 1) set_wr1(rnd_addr(), $urandom);
      if ($urandom_range(0, 1) == 1) set_wr2(rnd_addr(), $urandom);
      if ($urandom_range(0, 1) == 1) set_iss(rnd_addr());
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
